// File: rtl/cmd_queue_axil_responder.sv
// AXI4-Lite slave backing a word-addressed command/status memory, plus a backdoor port and B-handshake counter.
// Optional macro AXIL_DECERR_EN: out-of-range accesses answer DECERR instead of wrapping modulo the depth.
module cmd_queue_axil_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int IDX_W = $clog2(DEPTH_WORDS),
  localparam int STRB_W = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0]     s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic                  bd_we,
  input  logic [IDX_W-1:0]      bd_addr,
  input  logic [DATA_WIDTH-1:0] bd_wdata,
  output logic [DATA_WIDTH-1:0] bd_rdata,
  output logic [31:0]           wr_count
);

  localparam int OFS_W = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_fire, w_fire, aw_have, w_have;
  logic                  commit_any, commit_mem;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_in_range, rd_in_range;
  logic [1:0]            wr_resp;

  // A write commits on the edge where both halves are present, whether just captured or held from earlier.
  always_comb begin
    aw_fire = s_axi_awvalid && s_axi_awready;
    w_fire = s_axi_wvalid && s_axi_wready;
    aw_have = aw_held || aw_fire;
    w_have = w_held || w_fire;
    commit_any = !rst && (wr_state == WR_IDLE) && aw_have && w_have;
    wr_addr = aw_fire ? s_axi_awaddr : aw_addr_q;
    wr_data = w_fire ? s_axi_wdata : w_data_q;
    wr_strb = w_fire ? s_axi_wstrb : w_strb_q;
    wr_off = wr_addr - BASE_ADDR;
    rd_off = s_axi_araddr - BASE_ADDR;
    wr_idx = wr_off[OFS_W +: IDX_W];
    rd_idx = rd_off[OFS_W +: IDX_W];
    wr_in_range = (wr_off >> (OFS_W + IDX_W)) == '0;
    rd_in_range = (rd_off >> (OFS_W + IDX_W)) == '0;
`ifdef AXIL_DECERR_EN
    commit_mem = commit_any && wr_in_range;
    wr_resp = wr_in_range ? RESP_OKAY : RESP_DECERR;
`else
    commit_mem = commit_any;
    wr_resp = RESP_OKAY;
`endif
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, wr_off, rd_off, wr_in_range, rd_in_range};

  // Backdoor write goes first so an AXI commit to the same word overrides it.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (commit_mem)
      for (int b = 0; b < STRB_W; b++)
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
      wr_count <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_fire) aw_addr_q <= s_axi_awaddr;
          if (w_fire) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
          end
          if (aw_have && w_have) begin
            aw_held <= 1'b0;
            w_held <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp <= wr_resp;
            wr_state <= WR_RESP;
          end else begin
            aw_held <= aw_have;
            w_held <= w_have;
            s_axi_awready <= !aw_have;
            s_axi_wready <= !w_have;
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp <= RESP_OKAY;
            s_axi_awready <= 1'b1;
            s_axi_wready <= 1'b1;
            wr_count <= wr_count + 32'd1;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Reads sample memory before this edge's writes land, so a colliding write is not visible yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      bd_rdata <= '0;
    end else begin
      bd_rdata <= mem[bd_addr];
      case (rd_state)
        RD_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid <= 1'b1;
            rd_state <= RD_DATA;
`ifdef AXIL_DECERR_EN
            if (rd_in_range) begin
              s_axi_rdata <= mem[rd_idx];
              s_axi_rresp <= RESP_OKAY;
            end else begin
              s_axi_rdata <= '0;
              s_axi_rresp <= RESP_DECERR;
            end
`else
            s_axi_rdata <= mem[rd_idx];
            s_axi_rresp <= RESP_OKAY;
`endif
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            s_axi_arready <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule
